btn_debounce: RTL and testbench



---
 rtl/btn_pkg.sv | 12 +
 rtl/btn_debounce_ch.sv | 164 ++++++++++++++++
 rtl/btn_debounce.sv | 73 +++++++
 tb/tb_btn_debounce.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types for the push-button debouncer.
// The state enum is kept here so that any future button peripheral can decode it.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        BOUNCE_P = 2'd1,
        PRESSED  = 2'd2,
        BOUNCE_R = 2'd3
    } btn_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, debounce FSM advanced on the shared
// tick, hold counter for long-press detection and registered event pulses.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 10,
    parameter int LONG_TICKS     = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_btn,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam int                HCNT_W   = $clog2(LONG_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(LONG_TICKS);

    logic              r_sync1;
    logic              r_sync2;
    btn_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [HCNT_W-1:0] r_hcnt;
    logic              r_btn;
    logic              r_press;
    logic              r_release;
    logic              r_long;

    logic              w_s;
    btn_state_e        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [HCNT_W-1:0] w_hcnt_nxt;
    logic              w_btn_nxt;
    logic              w_press_nxt;
    logic              w_release_nxt;
    logic              w_long_nxt;

    // Reset value 0 means "released" after polarity normalisation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_btn     <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_btn     <= w_btn_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;
        end
    end

    // With DEBOUNCE_TICKS == 1 the bounce states are skipped entirely, so the
    // first differing tick already flips the level.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hcnt_nxt    = r_hcnt;
        w_btn_nxt     = r_btn;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;

        if (i_tick) begin
            case (r_state)
                RELEASED: begin
                    if (w_s) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            w_state_nxt = PRESSED;
                            w_cnt_nxt   = '0;
                            w_hcnt_nxt  = '0;
                            w_btn_nxt   = 1'b1;
                            w_press_nxt = 1'b1;
                        end else begin
                            w_state_nxt = BOUNCE_P;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                BOUNCE_P: begin
                    if (!w_s) begin
                        w_state_nxt = RELEASED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                        w_hcnt_nxt  = '0;
                        w_btn_nxt   = 1'b1;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!w_s) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            w_state_nxt   = RELEASED;
                            w_cnt_nxt     = '0;
                            w_hcnt_nxt    = '0;
                            w_btn_nxt     = 1'b0;
                            w_release_nxt = 1'b1;
                        end else begin
                            w_state_nxt = BOUNCE_R;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end else if (r_hcnt != HCNT_MAX) begin
                        w_hcnt_nxt = r_hcnt + HCNT_W'(1);
                        w_long_nxt = (r_hcnt == HCNT_MAX - HCNT_W'(1));
                    end
                end
                BOUNCE_R: begin
                    // hcnt is left untouched so a release glitch cannot re-arm long_o.
                    if (w_s) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt   = RELEASED;
                        w_cnt_nxt     = '0;
                        w_hcnt_nxt    = '0;
                        w_btn_nxt     = 1'b0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                    w_hcnt_nxt  = '0;
                    w_btn_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign o_btn     = r_btn;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/btn_debounce.sv
// Push-button front end: polarity normalisation, one shared sample-tick prescaler
// and NUM_BTN independent debounce channels.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int                   NUM_BTN         = 7,
    parameter int                   FREQUENCY       = 25_000_000,
    parameter int                   TICK_HZ         = 1000,
    parameter int                   DEBOUNCE_TICKS  = 10,
    parameter int                   LONG_TICKS      = 1000,
    parameter logic [NUM_BTN-1:0]   ACTIVE_LOW_MASK = 7'b0000001
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] btn_o,
    output logic [NUM_BTN-1:0] press_o,
    output logic [NUM_BTN-1:0] release_o,
    output logic [NUM_BTN-1:0] long_o
);

    localparam int DIV   = FREQUENCY / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (FREQUENCY < TICK_HZ) begin : g_chk_freq
        $fatal(1, "btn_debounce: FREQUENCY must be >= TICK_HZ");
    end
    if (DEBOUNCE_TICKS < 1) begin : g_chk_deb
        $fatal(1, "btn_debounce: DEBOUNCE_TICKS must be >= 1");
    end
    if (LONG_TICKS <= DEBOUNCE_TICKS) begin : g_chk_long
        $fatal(1, "btn_debounce: LONG_TICKS must exceed DEBOUNCE_TICKS");
    end
    if (NUM_BTN < 1) begin : g_chk_num
        $fatal(1, "btn_debounce: NUM_BTN must be >= 1");
    end

    logic [PRE_W-1:0]   r_presc;
    logic               w_tick;
    logic [NUM_BTN-1:0] w_raw;

    // First tick lands DIV cycles after reset release, then every DIV cycles.
    assign w_tick = (r_presc == PRE_W'(DIV - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    assign w_raw = btn_i ^ ACTIVE_LOW_MASK;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS)
        ) u_ch (
            .i_clk     (clk_i),
            .i_rst_n   (rst_ni),
            .i_tick    (w_tick),
            .i_raw     (w_raw[g]),
            .o_btn     (btn_o[g]),
            .o_press   (press_o[g]),
            .o_release (release_o[g]),
            .o_long    (long_o[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus random button
// activity, compared every cycle against a run-length model of the debouncer.
module tb_btn_debounce;

    localparam int         NB   = 2;
    localparam int         DIV  = 10;
    localparam int         DT   = 3;
    localparam int         LT   = 20;
    localparam logic [1:0] MASK = 2'b01;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_i = 2'b01;
    logic [NB-1:0] btn_o;
    logic [NB-1:0] press_o;
    logic [NB-1:0] release_o;
    logic [NB-1:0] long_o;

    int total = 0;
    int bad   = 0;
    int tcyc  = 0;

    always #5 clk = ~clk;

    btn_debounce #(
        .NUM_BTN         (NB),
        .FREQUENCY       (1000),
        .TICK_HZ         (100),
        .DEBOUNCE_TICKS  (DT),
        .LONG_TICKS      (LT),
        .ACTIVE_LOW_MASK (MASK)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .btn_i     (btn_i),
        .btn_o     (btn_o),
        .press_o   (press_o),
        .release_o (release_o),
        .long_o    (long_o)
    );

    // Model: level flips after DT consecutive differing ticks; a matching tick
    // clears the run; a matching tick with no run in progress counts hold time.
    logic [NB-1:0] mBtn = '0;
    logic [NB-1:0] mPress = '0;
    logic [NB-1:0] mRelease = '0;
    logic [NB-1:0] mLong = '0;
    logic [NB-1:0] sh1 = '0;
    logic [NB-1:0] sh2 = '0;
    int            mRun[NB];
    int            mHeld[NB];
    int            mCyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBtn = '0; mPress = '0; mRelease = '0; mLong = '0;
            sh1 = '0; sh2 = '0; mCyc = 0;
            for (int b = 0; b < NB; b++) begin
                mRun[b] = 0;
                mHeld[b] = 0;
            end
        end else begin
            mPress = '0; mRelease = '0; mLong = '0;
            if (mCyc % DIV == DIV - 1) begin
                for (int b = 0; b < NB; b++) begin
                    if (sh2[b] != mBtn[b]) begin
                        mRun[b]++;
                        if (mRun[b] == DT) begin
                            mRun[b] = 0;
                            mBtn[b] = sh2[b];
                            if (sh2[b]) begin
                                mPress[b] = 1'b1;
                                mHeld[b] = 0;
                            end else begin
                                mRelease[b] = 1'b1;
                            end
                        end
                    end else if (mRun[b] != 0) begin
                        mRun[b] = 0;
                    end else if (mBtn[b] && mHeld[b] < LT) begin
                        mHeld[b]++;
                        if (mHeld[b] == LT) mLong[b] = 1'b1;
                    end
                end
            end
            mCyc++;
            sh2 = sh1;
            sh1 = btn_i ^ MASK;
        end
    end

    always @(posedge clk) tcyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("btn_o", 32'(btn_o), 32'(mBtn));
        checkOutput("press_o", 32'(press_o), 32'(mPress));
        checkOutput("release_o", 32'(release_o), 32'(mRelease));
        checkOutput("long_o", 32'(long_o), 32'(mLong));
    end

    int pressCnt[NB];
    int releaseCnt[NB];
    int longCnt[NB];
    int highCnt[NB];
    int lastPressCyc[NB];
    int lastLongCyc[NB];
    int bothPress = 0;
    int bothRelease = 0;

    initial begin
        for (int b = 0; b < NB; b++) begin
            pressCnt[b] = 0; releaseCnt[b] = 0; longCnt[b] = 0; highCnt[b] = 0;
            lastPressCyc[b] = 0; lastLongCyc[b] = 0;
        end
    end

    always @(negedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (press_o[b] === 1'b1) begin pressCnt[b]++; lastPressCyc[b] = tcyc; end
            if (release_o[b] === 1'b1) releaseCnt[b]++;
            if (long_o[b] === 1'b1) begin longCnt[b]++; lastLongCyc[b] = tcyc; end
            if (btn_o[b] === 1'b1) highCnt[b]++;
        end
        if (press_o === 2'b11) bothPress++;
        if (release_o === 2'b11) bothRelease++;
    end

    // All stimulus tasks start and end 2 time units after a rising edge.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [NB-1:0] b, input int n);
        btn_i = b;
        waitCycles(n);
    endtask

    task automatic waitPress(input int bit_idx, input int base, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (pressCnt[bit_idx] != base) break;
            waitCycles(1);
        end
    endtask

    int pulses0, t0, bp0, bp1, br1, bl1, bh0, bh1, bb, d;

    initial begin
        waitCycles(3);
        checkOutput("reset_btn_o", 32'(btn_o), 32'd0);
        checkOutput("reset_press_o", 32'(press_o), 32'd0);
        checkOutput("reset_release_o", 32'(release_o), 32'd0);
        checkOutput("reset_long_o", 32'(long_o), 32'd0);
        rst_n = 1'b1;
        pulses0 = pressCnt[0] + pressCnt[1] + releaseCnt[0] + releaseCnt[1] + longCnt[0] + longCnt[1];
        applyStimulus(2'b01, 200);
        checkOutput("idle_no_pulses",
                    32'(pressCnt[0] + pressCnt[1] + releaseCnt[0] + releaseCnt[1] + longCnt[0] + longCnt[1] - pulses0),
                    32'd0);

        // Clean press on bit 1, then hold long enough for the long-press pulse.
        bp1 = pressCnt[1]; bl1 = longCnt[1]; br1 = releaseCnt[1]; bh0 = highCnt[0];
        t0 = tcyc;
        btn_i = 2'b11;
        waitPress(1, bp1, 40);
        checkOutput("press_seen", 32'(pressCnt[1] - bp1), 32'd1);
        d = lastPressCyc[1] - t0;
        checkOutput("press_latency_in_23_33", 32'(d >= 23 && d <= 33), 32'd1);
        checkOutput("press_btn_o", 32'(btn_o), 32'b10);
        applyStimulus(2'b11, 270);
        checkOutput("long_once", 32'(longCnt[1] - bl1), 32'd1);
        d = lastLongCyc[1] - lastPressCyc[1];
        checkOutput("long_delay_190_210", 32'(d >= 190 && d <= 210), 32'd1);
        checkOutput("press_once", 32'(pressCnt[1] - bp1), 32'd1);
        applyStimulus(2'b01, 50);
        checkOutput("release_once", 32'(releaseCnt[1] - br1), 32'd1);
        checkOutput("release_btn_o", 32'(btn_o), 32'd0);
        checkOutput("bit0_stays_low", 32'(highCnt[0] - bh0), 32'd0);

        // 15-cycle pulses span at most two ticks, fewer than DT.
        bp1 = pressCnt[1]; bh1 = highCnt[1];
        for (int i = 0; i < 7; i++) applyStimulus((i % 2 == 0) ? 2'b11 : 2'b01, 15);
        applyStimulus(2'b01, 50);
        checkOutput("bounce_no_press", 32'(pressCnt[1] - bp1), 32'd0);
        checkOutput("bounce_btn_never_high", 32'(highCnt[1] - bh1), 32'd0);

        // Both pressed together, bit 0 active-low.
        bb = bothPress; bp0 = pressCnt[0]; bp1 = pressCnt[1];
        applyStimulus(2'b10, 40);
        checkOutput("simul_press_same_cycle", 32'(bothPress - bb), 32'd1);
        checkOutput("simul_press_bit0", 32'(pressCnt[0] - bp0), 32'd1);
        checkOutput("simul_btn_o", 32'(btn_o), 32'b11);
        bb = bothRelease;
        applyStimulus(2'b01, 50);
        checkOutput("simul_release_same_cycle", 32'(bothRelease - bb), 32'd1);

        // Reset during BOUNCE_P, then during PRESSED.
        bp1 = pressCnt[1]; br1 = releaseCnt[1];
        applyStimulus(2'b11, 15);
        checkOutput("bounce_p_btn_low", 32'(btn_o), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_bp_btn_o", 32'(btn_o), 32'd0);
        waitCycles(3);
        rst_n = 1'b1;
        waitPress(1, bp1, 40);
        checkOutput("rst_bp_redebounce", 32'(pressCnt[1] - bp1), 32'd1);
        waitCycles(5);
        checkOutput("pressed_before_rst", 32'(btn_o), 32'b10);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_pr_btn_o", 32'(btn_o), 32'd0);
        checkOutput("rst_pr_release_o", 32'(release_o), 32'd0);
        waitCycles(3);
        rst_n = 1'b1;
        waitPress(1, bp1 + 1, 40);
        checkOutput("rst_pr_redebounce", 32'(pressCnt[1] - bp1), 32'd2);
        checkOutput("rst_no_release", 32'(releaseCnt[1] - br1), 32'd0);
        applyStimulus(2'b01, 50);

        // Random activity, including occasional resets.
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                waitCycles($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            applyStimulus(2'($urandom_range(0, 3)), $urandom_range(1, 50));
        end
        applyStimulus(2'b01, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
